// File: rtl/move_check_sequencer.sv
// move_check_sequencer
// Sequences one move-legality check per request. It latches the squares,
// fetches the moving piece and the destination square from the board, and
// rejects moves that fail piece-independent rules. Otherwise it restarts the
// checker bank, lets the selected per-piece checker run, and reports one
// registered verdict that is held until acknowledged.
// Optional feature macro: CHECK_TIMEOUT_EN adds a RUN-cycle watchdog
// (result_code 3). Without it RUN waits for the checker indefinitely.
module move_check_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2:0]             old_x,
    input  logic [2:0]             old_y,
    input  logic [2:0]             new_x,
    input  logic [2:0]             new_y,
    input  logic [7:0][7:0][3:0]   board_in,
    input  logic [5:0]             chk_valid,
    input  logic [5:0]             chk_done,
    output logic                   chk_rst_n,
    output logic [5:0]             chk_sel,
    output logic [2:0]             old_x_q,
    output logic [2:0]             old_y_q,
    output logic [2:0]             new_x_q,
    output logic [2:0]             new_y_q,
    output logic [2:0]             h_delta,
    output logic [2:0]             v_delta,
    output logic [3:0]             piece_type,
    output logic                   busy,
    output logic                   result_valid,
    output logic                   move_ok,
    output logic [1:0]             result_code,
    input  logic                   result_ack
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        PRECHECK = 3'd2,
        RESTART  = 3'd3,
        RUN      = 3'd4,
        REPORT   = 3'd5
    } state_t;

    localparam logic [1:0] CODE_CHECKER = 2'd0;
    localparam logic [1:0] CODE_EMPTY   = 2'd1;
    localparam logic [1:0] CODE_ILLEGAL = 2'd2;
`ifdef CHECK_TIMEOUT_EN
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
`endif

    state_t      state_reg, state_next;
    logic [2:0]  old_x_reg, old_x_next;
    logic [2:0]  old_y_reg, old_y_next;
    logic [2:0]  new_x_reg, new_x_next;
    logic [2:0]  new_y_reg, new_y_next;
    logic [3:0]  piece_reg, piece_next;
    logic [3:0]  dest_reg, dest_next;
    logic [2:0]  h_delta_reg, h_delta_next;
    logic [2:0]  v_delta_reg, v_delta_next;
    logic [5:0]  chk_sel_reg, chk_sel_next;
    logic        chk_rst_n_reg, chk_rst_n_next;
    logic        busy_reg, busy_next;
    logic        result_valid_reg, result_valid_next;
    logic        move_ok_reg, move_ok_next;
    logic [1:0]  result_code_reg, result_code_next;
    logic        sticky_reg, sticky_next;
`ifdef CHECK_TIMEOUT_EN
    logic [7:0]  timeout_cnt_reg, timeout_cnt_next;
`endif

    // One-hot checker select decoded from the piece kind (bit gi <-> kind gi+1)
    logic [5:0] sel_decode;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_sel_decode
            assign sel_decode[gi] = (piece_reg[2:0] == 3'(gi + 1));
        end
    endgenerate

    // Only the selected checker's outputs are looked at
    logic sel_valid;
    logic sel_done;
    assign sel_valid = |(chk_valid & chk_sel_reg);
    assign sel_done  = |(chk_done  & chk_sel_reg);

    // Piece-independent rejection terms evaluated in PRECHECK
    logic src_bad;
    logic null_move;
    logic own_capture;
    assign src_bad     = (piece_reg[2:0] == 3'd0) || (piece_reg[2:0] == 3'd7);
    assign null_move   = (old_x_reg == new_x_reg) && (old_y_reg == new_y_reg);
    assign own_capture = (dest_reg != 4'd0) && (dest_reg[3] == piece_reg[3]);

    // Next-state and next-output decode; every register defaults to holding
    always_comb begin
        state_next        = state_reg;
        old_x_next        = old_x_reg;
        old_y_next        = old_y_reg;
        new_x_next        = new_x_reg;
        new_y_next        = new_y_reg;
        piece_next        = piece_reg;
        dest_next         = dest_reg;
        h_delta_next      = h_delta_reg;
        v_delta_next      = v_delta_reg;
        chk_sel_next      = chk_sel_reg;
        move_ok_next      = move_ok_reg;
        result_code_next  = result_code_reg;
        sticky_next       = sticky_reg;
`ifdef CHECK_TIMEOUT_EN
        timeout_cnt_next  = timeout_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    old_x_next = old_x;
                    old_y_next = old_y;
                    new_x_next = new_x;
                    new_y_next = new_y;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                piece_next   = board_in[old_y_reg][old_x_reg];
                dest_next    = board_in[new_y_reg][new_x_reg];
                h_delta_next = (new_x_reg >= old_x_reg) ? (new_x_reg - old_x_reg)
                                                        : (old_x_reg - new_x_reg);
                v_delta_next = (new_y_reg >= old_y_reg) ? (new_y_reg - old_y_reg)
                                                        : (old_y_reg - new_y_reg);
                state_next   = PRECHECK;
            end
            PRECHECK: begin
                if (src_bad) begin
                    move_ok_next     = 1'b0;
                    result_code_next = CODE_EMPTY;
                    state_next       = REPORT;
                end else if (null_move || own_capture) begin
                    move_ok_next     = 1'b0;
                    result_code_next = CODE_ILLEGAL;
                    state_next       = REPORT;
                end else begin
                    chk_sel_next = sel_decode;
                    state_next   = RESTART;
                end
            end
            RESTART: begin
                sticky_next = 1'b0;
`ifdef CHECK_TIMEOUT_EN
                timeout_cnt_next = 8'd0;
`endif
                state_next  = RUN;
            end
            RUN: begin
                // The checker's valid pulse precedes its done, so remember it
                sticky_next = sticky_reg | sel_valid;
                if (sel_done) begin
                    move_ok_next     = sticky_reg | sel_valid;
                    result_code_next = CODE_CHECKER;
                    state_next       = REPORT;
                end
`ifdef CHECK_TIMEOUT_EN
                else if ((timeout_cnt_reg + 8'd1) == TIMEOUT_LIMIT) begin
                    move_ok_next     = 1'b0;
                    result_code_next = CODE_TIMEOUT;
                    state_next       = REPORT;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + 8'd1;
                end
`endif
            end
            REPORT: begin
                if (result_ack) begin
                    chk_sel_next = 6'd0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered
        busy_next         = (state_next != IDLE);
        result_valid_next = (state_next == REPORT);
        chk_rst_n_next    = (state_next != RESTART);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            old_x_reg        <= 3'd0;
            old_y_reg        <= 3'd0;
            new_x_reg        <= 3'd0;
            new_y_reg        <= 3'd0;
            piece_reg        <= 4'd0;
            dest_reg         <= 4'd0;
            h_delta_reg      <= 3'd0;
            v_delta_reg      <= 3'd0;
            chk_sel_reg      <= 6'd0;
            chk_rst_n_reg    <= 1'b1;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            move_ok_reg      <= 1'b0;
            result_code_reg  <= 2'd0;
            sticky_reg       <= 1'b0;
`ifdef CHECK_TIMEOUT_EN
            timeout_cnt_reg  <= 8'd0;
`endif
        end else begin
            state_reg        <= state_next;
            old_x_reg        <= old_x_next;
            old_y_reg        <= old_y_next;
            new_x_reg        <= new_x_next;
            new_y_reg        <= new_y_next;
            piece_reg        <= piece_next;
            dest_reg         <= dest_next;
            h_delta_reg      <= h_delta_next;
            v_delta_reg      <= v_delta_next;
            chk_sel_reg      <= chk_sel_next;
            chk_rst_n_reg    <= chk_rst_n_next;
            busy_reg         <= busy_next;
            result_valid_reg <= result_valid_next;
            move_ok_reg      <= move_ok_next;
            result_code_reg  <= result_code_next;
            sticky_reg       <= sticky_next;
`ifdef CHECK_TIMEOUT_EN
            timeout_cnt_reg  <= timeout_cnt_next;
`endif
        end
    end

    assign chk_rst_n    = chk_rst_n_reg;
    assign chk_sel      = chk_sel_reg;
    assign old_x_q      = old_x_reg;
    assign old_y_q      = old_y_reg;
    assign new_x_q      = new_x_reg;
    assign new_y_q      = new_y_reg;
    assign h_delta      = h_delta_reg;
    assign v_delta      = v_delta_reg;
    assign piece_type   = piece_reg;
    assign busy         = busy_reg;
    assign result_valid = result_valid_reg;
    assign move_ok      = move_ok_reg;
    assign result_code  = result_code_reg;

endmodule

// File: tb/tb_move_check_sequencer.sv
// Directed testbench for move_check_sequencer. A small behavioural checker
// model answers on the selected lane: idle the cycle after restart, valid in
// the next cycle, done in the one after. Latency is counted in clock edges
// after the edge that samples start (check path 6, rejection 2, watchdog 7).
module tb_move_check_sequencer;

    logic                 CLOCK_50;
    logic                 reset_n;
    logic                 start;
    logic [2:0]           old_x, old_y, new_x, new_y;
    logic [7:0][7:0][3:0] board;
    logic [5:0]           chk_valid, chk_done;
    logic                 chk_rst_n;
    logic [5:0]           chk_sel;
    logic [2:0]           old_x_q, old_y_q, new_x_q, new_y_q;
    logic [2:0]           h_delta, v_delta;
    logic [3:0]           piece_type;
    logic                 busy, result_valid, move_ok;
    logic [1:0]           result_code;
    logic                 result_ack;

    logic [5:0] valid_mask, done_mask, noise_valid, noise_done;
    logic [1:0] ck_cnt = 2'd3;
    int         rst_low_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    int         edges;
    int         rst_before;

    move_check_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .start        (start),
        .old_x        (old_x),
        .old_y        (old_y),
        .new_x        (new_x),
        .new_y        (new_y),
        .board_in     (board),
        .chk_valid    (chk_valid),
        .chk_done     (chk_done),
        .chk_rst_n    (chk_rst_n),
        .chk_sel      (chk_sel),
        .old_x_q      (old_x_q),
        .old_y_q      (old_y_q),
        .new_x_q      (new_x_q),
        .new_y_q      (new_y_q),
        .h_delta      (h_delta),
        .v_delta      (v_delta),
        .piece_type   (piece_type),
        .busy         (busy),
        .result_valid (result_valid),
        .move_ok      (move_ok),
        .result_code  (result_code),
        .result_ack   (result_ack)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Checker model: phase counter restarted by chk_rst_n
    always @(posedge CLOCK_50) begin
        if (!chk_rst_n) ck_cnt <= 2'd0;
        else if (ck_cnt != 2'd3) ck_cnt <= ck_cnt + 2'd1;
    end
    assign chk_valid = ((ck_cnt == 2'd1) ? valid_mask : 6'd0) | noise_valid;
    assign chk_done  = ((ck_cnt == 2'd2) ? done_mask  : 6'd0) | noise_done;

    // Number of clock cycles spent with the checker restart asserted
    always @(posedge CLOCK_50) begin
        if (!chk_rst_n) rst_low_cnt <= rst_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] ox, input logic [2:0] oy,
                         input logic [2:0] nx, input logic [2:0] ny);
        @(negedge CLOCK_50);
        old_x = ox; old_y = oy; new_x = nx; new_y = ny;
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
    endtask

    task automatic do_request(input string name,
                              input logic [2:0] ox, input logic [2:0] oy,
                              input logic [2:0] nx, input logic [2:0] ny,
                              output int n);
        rst_before = rst_low_cnt;
        issue(ox, oy, nx, ny);
        n = 0;
        while (!result_valid && n < 100) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        $display("txn %s edges=%0d valid=%0b ok=%0b code=%0d sel=%b", name, n,
                 result_valid, move_ok, result_code, chk_sel);
    endtask

    task automatic ack();
        result_ack = 1'b1;
        @(posedge CLOCK_50);
        #1;
        result_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; result_ack = 1'b0;
        old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd0;
        board = '0;
        valid_mask = 6'd0; done_mask = 6'd0; noise_valid = 6'd0; noise_done = 6'd0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_busy",   32'(busy), 0);
        check("rst_valid",  32'(result_valid), 0);
        check("rst_chkrst", 32'(chk_rst_n), 1);
        check("rst_sel",    32'(chk_sel), 0);
        check("rst_ok",     32'(move_ok), 0);
        check("rst_code",   32'(result_code), 0);
        check("rst_piece",  32'(piece_type), 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // White queen (3,0) -> (3,4); noise on unselected lanes must be ignored
        board[0][3] = 4'h5;
        valid_mask = 'h10; done_mask = 'h10; noise_valid = 'h21; noise_done = 'h02;
        do_request("queen", 3'd3, 3'd0, 3'd3, 3'd4, edges);
        check("q_lat",    32'(edges), 6);
        check("q_ok",     32'(move_ok), 1);
        check("q_code",   32'(result_code), 0);
        check("q_hd",     32'(h_delta), 0);
        check("q_vd",     32'(v_delta), 4);
        check("q_sel",    32'(chk_sel), 'h10);
        check("q_piece",  32'(piece_type), 5);
        check("q_oldx",   32'(old_x_q), 3);
        check("q_newy",   32'(new_y_q), 4);
        check("q_rstcyc", 32'(rst_low_cnt - rst_before), 1);
        ack();
        check("q_ack_valid", 32'(result_valid), 0);
        check("q_ack_busy",  32'(busy), 0);
        check("q_ack_sel",   32'(chk_sel), 0);
        noise_valid = 'h00; noise_done = 'h00;

        // Black knight (1,1) -> (2,3), checker never reports valid
        board = '0;
        board[1][1] = 4'hA;
        valid_mask = 'h00; done_mask = 'h02;
        do_request("knight_bad", 3'd1, 3'd1, 3'd2, 3'd3, edges);
        check("n_lat",  32'(edges), 6);
        check("n_ok",   32'(move_ok), 0);
        check("n_code", 32'(result_code), 0);
        check("n_sel",  32'(chk_sel), 'h02);
        check("n_hd",   32'(h_delta), 1);
        check("n_vd",   32'(v_delta), 2);
        ack();

        // Empty source (2,2)
        board = '0;
        do_request("empty", 3'd2, 3'd2, 3'd2, 3'd5, edges);
        check("e_lat",    32'(edges), 2);
        check("e_ok",     32'(move_ok), 0);
        check("e_code",   32'(result_code), 1);
        check("e_sel",    32'(chk_sel), 0);
        check("e_rstcyc", 32'(rst_low_cnt - rst_before), 0);
        ack();

        // Invalid piece kind 7 counts as an empty source
        board[6][6] = 4'h7;
        do_request("kind7", 3'd6, 3'd6, 3'd6, 3'd7, edges);
        check("k7_code", 32'(result_code), 1);
        ack();

        // Null move with a knight
        board = '0;
        board[4][4] = 4'h2;
        do_request("null", 3'd4, 3'd4, 3'd4, 3'd4, edges);
        check("nm_lat",  32'(edges), 2);
        check("nm_code", 32'(result_code), 2);
        ack();

        // Black rook captures white pawn: goes to the rook checker
        board = '0;
        board[0][0] = 4'hC; board[5][0] = 4'h1;
        valid_mask = 'h08; done_mask = 'h08;
        do_request("rook_cap", 3'd0, 3'd0, 3'd0, 3'd5, edges);
        check("rc_lat",  32'(edges), 6);
        check("rc_ok",   32'(move_ok), 1);
        check("rc_code", 32'(result_code), 0);
        check("rc_sel",  32'(chk_sel), 'h08);
        ack();

        // White rook onto own pawn, then hold the result with ack low
        board[0][0] = 4'h4;
        do_request("rook_own", 3'd0, 3'd0, 3'd0, 3'd5, edges);
        check("ro_lat",  32'(edges), 2);
        check("ro_ok",   32'(move_ok), 0);
        check("ro_code", 32'(result_code), 2);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge CLOCK_50);
            #1;
            check("hold_valid", 32'(result_valid), 1);
            check("hold_code",  32'(result_code), 2);
        end
        start = 1'b1; result_ack = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0; result_ack = 1'b0;
        check("ackstart_valid", 32'(result_valid), 0);
        check("ackstart_busy",  32'(busy), 0);
        @(posedge CLOCK_50);
        #1;
        check("ackstart_noqueue", 32'(busy), 0);

        // King whose checker never finishes
        board = '0;
        board[0][4] = 4'h6;
        valid_mask = 'h00; done_mask = 'h00;
`ifdef CHECK_TIMEOUT_EN
        do_request("king_hang", 3'd4, 3'd0, 3'd4, 3'd1, edges);
        check("to_lat",  32'(edges), 7);
        check("to_ok",   32'(move_ok), 0);
        check("to_code", 32'(result_code), 3);
        ack();
`else
        issue(3'd4, 3'd0, 3'd4, 3'd1);
        for (int i = 0; i < 50; i++) begin
            @(posedge CLOCK_50);
            #1;
            check("hang_busy",  32'(busy), 1);
            check("hang_valid", 32'(result_valid), 0);
        end
        $display("txn king_hang busy=%0b after 50 cycles", busy);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
`endif

        // Reset asserted while the queen checker is in RUN
        board = '0;
        board[0][3] = 4'h5;
        valid_mask = 'h10; done_mask = 'h00;
        issue(3'd3, 3'd0, 3'd3, 3'd4);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("run_busy_pre", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_busy",   32'(busy), 0);
        check("mid_sel",    32'(chk_sel), 0);
        check("mid_chkrst", 32'(chk_rst_n), 1);
        check("mid_valid",  32'(result_valid), 0);
        $display("txn reset_in_run busy=%0b sel=%b", busy, chk_sel);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        done_mask = 'h10;
        do_request("queen_after_rst", 3'd3, 3'd0, 3'd3, 3'd4, edges);
        check("ar_lat",  32'(edges), 6);
        check("ar_ok",   32'(move_ok), 1);
        check("ar_code", 32'(result_code), 0);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
